// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: shared MIPS opcode/format contract between the program
// loader (encoder side) and the main control decoder (decoder side).
// Contents: 6-bit opcode constants, R-type funct constants and the 4-bit
// mnemonic codes used on the loader request interface.
package mips_isa_pkg;

  // Primary opcodes, bits 31:26 of the instruction word.
  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_ANDI = 6'd12;
  localparam logic [5:0] OP_ORI  = 6'd13;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_XORI = 6'd14;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_JAL  = 6'd3;
  localparam logic [5:0] OP_LUI  = 6'd15;

  // R-type funct field, bits 5:0.
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  // Mnemonic codes carried on the request interface.
  typedef enum logic [3:0] {
    MN_ADD  = 4'd0,
    MN_SUB  = 4'd1,
    MN_AND  = 4'd2,
    MN_OR   = 4'd3,
    MN_SLT  = 4'd4,
    MN_LW   = 4'd5,
    MN_SW   = 4'd6,
    MN_ADDI = 4'd7,
    MN_ANDI = 4'd8,
    MN_ORI  = 4'd9,
    MN_SLTI = 4'd10,
    MN_XORI = 4'd11,
    MN_BNE  = 4'd12,
    MN_J    = 4'd13,
    MN_JAL  = 4'd14,
    MN_LUI  = 4'd15
  } mnem_e;

endpackage

// File: rtl/inst_encode.sv
// inst_encode: combinational mnemonic-to-instruction-word encoder.
// Ports:
//   op_i     mnemonic code (mips_isa_pkg::mnem_e values)
//   rs_i, rt_i, rd_i, shamt_i  register / shift fields
//   imm_i    16-bit immediate (I-type)
//   target_i 26-bit jump target (J-type)
//   word_o   encoded 32-bit MIPS instruction
module inst_encode
  import mips_isa_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = 32'd0;
    case (op_i)
      MN_ADD:  word_o = {OP_R, rs_i, rt_i, rd_i, shamt_i, FN_ADD};
      MN_SUB:  word_o = {OP_R, rs_i, rt_i, rd_i, shamt_i, FN_SUB};
      MN_AND:  word_o = {OP_R, rs_i, rt_i, rd_i, shamt_i, FN_AND};
      MN_OR:   word_o = {OP_R, rs_i, rt_i, rd_i, shamt_i, FN_OR};
      MN_SLT:  word_o = {OP_R, rs_i, rt_i, rd_i, shamt_i, FN_SLT};
      MN_LW:   word_o = {OP_LW,   rs_i, rt_i, imm_i};
      MN_SW:   word_o = {OP_SW,   rs_i, rt_i, imm_i};
      MN_ADDI: word_o = {OP_ADDI, rs_i, rt_i, imm_i};
      MN_ANDI: word_o = {OP_ANDI, rs_i, rt_i, imm_i};
      MN_ORI:  word_o = {OP_ORI,  rs_i, rt_i, imm_i};
      MN_SLTI: word_o = {OP_SLTI, rs_i, rt_i, imm_i};
      MN_XORI: word_o = {OP_XORI, rs_i, rt_i, imm_i};
      MN_BNE:  word_o = {OP_BNE,  rs_i, rt_i, imm_i};
      MN_J:    word_o = {OP_J,    target_i};
      MN_JAL:  word_o = {OP_JAL,  target_i};
      // LUI has no source register; the rs slot is forced to zero.
      MN_LUI:  word_o = {OP_LUI, 5'd0, rt_i, imm_i};
      default: word_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: accepts mnemonic-level instruction requests over a
// valid/ready handshake, encodes each into a MIPS word and writes the words
// to instruction memory at consecutive addresses starting from 0.
// Ports:
//   clk, reset (sync, active-low)
//   Req_Valid/Req_Ready          request handshake
//   Req_Op..Req_Target, Req_Last request fields, Last marks final word
//   Start                        restart a session from DONE
//   Imem_We/Imem_Addr/Imem_Wdata instruction-memory write port (1-cycle latency)
//   Count                        words accepted this session
//   Done                         session finished and all writes issued
//   Error                        DEPTH reached without Req_Last
module inst_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic [3:0]        Req_Op,
  input  logic [4:0]        Req_Rs,
  input  logic [4:0]        Req_Rt,
  input  logic [4:0]        Req_Rd,
  input  logic [4:0]        Req_Shamt,
  input  logic [15:0]       Req_Imm,
  input  logic [25:0]       Req_Target,
  input  logic              Req_Last,
  input  logic              Start,
  output logic              Imem_We,
  output logic [ADDR_W-1:0] Imem_Addr,
  output logic [31:0]       Imem_Wdata,
  output logic [ADDR_W:0]   Count,
  output logic              Done,
  output logic              Error
);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              error_q, error_d;

  logic [31:0]       enc_word;
  logic [ADDR_W:0]   count_inc;
  logic              accept;

  inst_encode u_encode (
    .op_i     (Req_Op),
    .rs_i     (Req_Rs),
    .rt_i     (Req_Rt),
    .rd_i     (Req_Rd),
    .shamt_i  (Req_Shamt),
    .imm_i    (Req_Imm),
    .target_i (Req_Target),
    .word_o   (enc_word)
  );

  // Ready depends only on registered state so it never loops back through
  // the requester's valid logic.
  assign Req_Ready = (state_q == ST_LOAD) && (count_q < DEPTH_C);
  assign accept    = Req_Valid && Req_Ready;
  assign count_inc = count_q + ONE_C;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    error_d = error_q;
    if (accept) begin
      we_d    = 1'b1;
      addr_d  = count_q[ADDR_W-1:0];
      wdata_d = enc_word;
      count_d = count_inc;
      if (Req_Last || (count_inc == DEPTH_C)) begin
        state_d = ST_DONE;
        // A Last on the final slot is a clean finish, not an overflow.
        error_d = !Req_Last;
      end
    end else if ((state_q == ST_DONE) && Start) begin
      state_d = ST_LOAD;
      count_d = '0;
      error_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      error_q <= error_d;
    end
  end

  assign Imem_We    = we_q;
  assign Imem_Addr  = addr_q;
  assign Imem_Wdata = wdata_q;
  assign Count      = count_q;
  // Done waits for the last strobe to leave the write port.
  assign Done       = (state_q == ST_DONE) && !we_q;
  assign Error      = error_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: instance A uses the default 256-word
// session, instance B a 4-word session with ADDR_W=2 so that DEPTH equals
// the full address space. A cycle-level reference model built from the
// encoding tables and session rules predicts every output.
module tb_inst_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared request fields.
  logic [3:0]  op;
  logic [4:0]  rs, rt, rd, sh;
  logic [15:0] imm;
  logic [25:0] tgt;

  // Per-instance control: index 0 = A, 1 = B.
  logic [1:0] rst_n, vld, lst, stt;

  logic        rdy_a, we_a, done_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  count_a;

  logic        rdy_b, we_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  count_b;

  inst_encoder_loader #(.ADDR_W(8), .DEPTH(256)) dut_a (
    .clk(clk), .reset(rst_n[0]), .Req_Valid(vld[0]), .Req_Ready(rdy_a),
    .Req_Op(op), .Req_Rs(rs), .Req_Rt(rt), .Req_Rd(rd), .Req_Shamt(sh),
    .Req_Imm(imm), .Req_Target(tgt), .Req_Last(lst[0]), .Start(stt[0]),
    .Imem_We(we_a), .Imem_Addr(addr_a), .Imem_Wdata(wdata_a),
    .Count(count_a), .Done(done_a), .Error(err_a)
  );

  inst_encoder_loader #(.ADDR_W(2), .DEPTH(4)) dut_b (
    .clk(clk), .reset(rst_n[1]), .Req_Valid(vld[1]), .Req_Ready(rdy_b),
    .Req_Op(op), .Req_Rs(rs), .Req_Rt(rt), .Req_Rd(rd), .Req_Shamt(sh),
    .Req_Imm(imm), .Req_Target(tgt), .Req_Last(lst[1]), .Start(stt[1]),
    .Imem_We(we_b), .Imem_Addr(addr_b), .Imem_Wdata(wdata_b),
    .Count(count_b), .Done(done_b), .Error(err_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Encoding tables indexed by mnemonic code.
  int opc_tbl[16] = '{0, 0, 0, 0, 0, 35, 43, 8, 12, 13, 10, 14, 5, 2, 3, 15};
  int fn_tbl[5]   = '{32, 34, 36, 37, 42};

  function automatic logic [31:0] ref_encode();
    logic [31:0] w;
    int m;
    m = int'(op);
    if (m < 5)
      w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn_tbl[m]);
    else if (m == 13 || m == 14)
      w = (32'(opc_tbl[m]) << 26) | 32'(tgt);
    else if (m == 15)
      w = (32'(opc_tbl[m]) << 26) | (32'(rt) << 16) | 32'(imm);
    else
      w = (32'(opc_tbl[m]) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    return w;
  endfunction

  // Reference model state per instance.
  int          depth[2] = '{256, 4};
  bit          m_load[2];
  int          m_count[2];
  bit          m_we[2];
  int          m_addr[2];
  logic [31:0] m_wdata[2];
  bit          m_err[2];
  int          txn = 0;

  task automatic model_reset(input int k);
    m_load[k]  = 1'b1;
    m_count[k] = 0;
    m_we[k]    = 1'b0;
    m_addr[k]  = 0;
    m_wdata[k] = 32'd0;
    m_err[k]   = 1'b0;
  endtask

  task automatic set_req(input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [4:0] h, input logic [15:0] i,
                         input logic [25:0] g);
    op = o; rs = s; rt = t; rd = d; sh = h; imm = i; tgt = g;
  endtask

  task automatic rand_req();
    set_req(4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            16'($urandom), 26'($urandom));
  endtask

  // One clock cycle on instance k with the other instance idle.
  task automatic step(input int k, input bit v, input bit l, input bit s, input bit r);
    bit exp_ready, acc;
    logic [31:0] o_rdy, o_we, o_addr, o_wdata, o_cnt, o_done, o_err;
    @(negedge clk);
    vld = '0; lst = '0; stt = '0; rst_n = 2'b11;
    vld[k] = v; lst[k] = l; stt[k] = s; rst_n[k] = r;
    #1;
    exp_ready = m_load[k] && (m_count[k] < depth[k]);
    o_rdy = (k == 0) ? 32'(rdy_a) : 32'(rdy_b);
    check($sformatf("ready%0d", k), o_rdy, 32'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    #1;
    if (!r) begin
      model_reset(k);
    end else if (acc) begin
      m_we[k]    = 1'b1;
      m_addr[k]  = m_count[k];
      m_wdata[k] = ref_encode();
      m_count[k] = m_count[k] + 1;
      if (l || m_count[k] == depth[k]) begin
        m_load[k] = 1'b0;
        m_err[k]  = !l;
      end
      txn++;
      $display("txn %0d inst %0d op %0d addr %0d word %h count %0d", txn, k, op,
               m_addr[k], m_wdata[k], m_count[k]);
    end else begin
      m_we[k] = 1'b0;
      if (!m_load[k] && s) begin
        m_load[k]  = 1'b1;
        m_count[k] = 0;
        m_err[k]   = 1'b0;
      end
    end
    m_we[1-k] = 1'b0;
    o_we    = (k == 0) ? 32'(we_a)    : 32'(we_b);
    o_addr  = (k == 0) ? 32'(addr_a)  : 32'(addr_b);
    o_wdata = (k == 0) ? wdata_a      : wdata_b;
    o_cnt   = (k == 0) ? 32'(count_a) : 32'(count_b);
    o_done  = (k == 0) ? 32'(done_a)  : 32'(done_b);
    o_err   = (k == 0) ? 32'(err_a)   : 32'(err_b);
    check($sformatf("we%0d", k),    o_we,    32'(m_we[k]));
    check($sformatf("addr%0d", k),  o_addr,  32'(m_addr[k]));
    check($sformatf("wdata%0d", k), o_wdata, m_wdata[k]);
    check($sformatf("count%0d", k), o_cnt,   32'(m_count[k]));
    check($sformatf("done%0d", k),  o_done,  32'(!m_load[k] && !m_we[k]));
    check($sformatf("error%0d", k), o_err,   32'(m_err[k]));
    // The idle instance must have dropped its strobe.
    check($sformatf("idle_we%0d", 1 - k), (k == 0) ? 32'(we_b) : 32'(we_a), 32'd0);
  endtask

  initial begin
    rand_req();
    vld = '0; lst = '0; stt = '0; rst_n = 2'b00;
    repeat (2) @(posedge clk);
    model_reset(0);
    model_reset(1);

    // Reset state on both instances.
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);

    // ADDI rs=1 rt=2 imm=FFFC.
    set_req(4'd7, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFC, 26'd0);
    step(0, 1, 0, 0, 1);
    check("addi_word", wdata_a, 32'h2022FFFC);

    // Fresh session, back-to-back ADD, SW, JAL(last).
    step(0, 0, 0, 0, 0);
    set_req(4'd0, 5'd3, 5'd4, 5'd5, 5'd0, 16'h0, 26'h0);
    step(0, 1, 0, 0, 1);
    check("add_word", wdata_a, 32'h00642820);
    set_req(4'd6, 5'd29, 5'd31, 5'd0, 5'd0, 16'd4, 26'h0);
    step(0, 1, 0, 0, 1);
    check("sw_word", wdata_a, 32'hAFBF0004);
    set_req(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
    step(0, 1, 1, 0, 1);
    check("jal_word", wdata_a, 32'h0C000010);
    check("jal_addr", 32'(addr_a), 32'd2);
    step(0, 1, 0, 0, 1);
    check("done_after_last", 32'(done_a), 32'd1);
    step(0, 0, 0, 1, 1);

    // LUI ignores rs.
    set_req(4'd15, 5'd7, 5'd8, 5'd0, 5'd0, 16'h1234, 26'h0);
    step(0, 1, 0, 0, 1);
    check("lui_word", wdata_a, 32'h3C081234);

    // Depth overflow on B, then ignored request in DONE, then restart.
    for (int i = 0; i < 4; i++) begin
      rand_req();
      step(1, 1, 0, 0, 1);
    end
    check("ovf_error", 32'(err_b), 32'd1);
    rand_req();
    step(1, 1, 0, 0, 1);
    check("ovf_done", 32'(done_b), 32'd1);
    step(1, 0, 0, 1, 1);
    check("restart_count", 32'(count_b), 32'd0);
    rand_req();
    step(1, 1, 0, 0, 1);
    check("restart_addr", 32'(addr_b), 32'd0);

    // Reset right after an accept drops the pending write and the new accept.
    rand_req();
    step(0, 1, 0, 0, 1);
    rand_req();
    step(0, 1, 0, 1, 0);

    // Randomized traffic on both instances.
    for (int n = 0; n < 1500; n++) begin
      int k;
      k = int'($urandom_range(0, 1));
      rand_req();
      step(k, ($urandom_range(0, 3) != 0),
           (k == 0) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 99) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
Program loader on the instruction-memory side of the main control decoder. It takes mnemonic-level instruction requests over a valid/ready handshake and encodes each one into a 32-bit MIPS word: opcode in bits 31:26, plus funct for R-type. It then writes the words into instruction memory at consecutive addresses from 0. The control decoder later fetches and decodes these same words, so this block is the encoder end of the opcode/format contract.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, maximum words per load session; 1 <= DEPTH <= 2^ADDR_W

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (reset==0 at a rising clk edge resets)
Req_Valid  in  1  request present
Req_Ready  out  1  block accepts the request this cycle
Req_Op  in  4  mnemonic code (see Decomposition)
Req_Rs  in  5  rs field
Req_Rt  in  5  rt field
Req_Rd  in  5  rd field (R-type only)
Req_Shamt  in  5  shamt field (R-type only)
Req_Imm  in  16  immediate (I-type)
Req_Target  in  26  jump target (J-type)
Req_Last  in  1  this request is the final instruction of the program
Start  in  1  restart a load session from DONE
Imem_We  out  1  instruction-memory write strobe, one cycle per word
Imem_Addr  out  ADDR_W  write word address
Imem_Wdata  out  32  encoded instruction
Count  out  ADDR_W+1  number of words accepted this session
Done  out  1  session finished and all writes issued
Error  out  1  DEPTH reached without Req_Last

Behaviour:
- States: LOAD and DONE.
- Reset: state=LOAD. Count=0, Imem_We=0, Imem_Addr=0, Imem_Wdata=0, Done=0, Error=0. A write pending when reset is sampled is dropped.
- Req_Ready = (state==LOAD) && (Count < DEPTH). It is combinational from state and Count only, never from Req_Valid.
- Accept = Req_Valid && Req_Ready. On accept in cycle N:
  - In cycle N+1: Imem_We=1, Imem_Addr=Count[ADDR_W-1:0] as sampled in N, Imem_Wdata=encode(request).
  - Count increments by 1.
  - Latency is 1 cycle. Throughput is 1 word/cycle; back-to-back accepts are allowed.
- No accept in a cycle: Imem_We=0 next cycle. Imem_Addr and Imem_Wdata hold their last values.
- Encoding:
  - R-type (ADD/SUB/AND/OR/SLT): {6'd0, rs, rt, rd, shamt, funct}. Funct values: ADD 32, SUB 34, AND 36, OR 37, SLT 42.
  - I-type (LW 35, SW 43, ADDI 8, ANDI 12, ORI 13, SLTI 10, XORI 14, BNE 5): {op, rs, rt, imm}.
  - LUI (15): {op, 5'd0, rt, imm}; Req_Rs is ignored.
  - J-type (J 2, JAL 3): {op, target}.
  - Fields not used by the format are ignored.
- LOAD->DONE on an accept with Req_Last=1, or on an accept that makes Count==DEPTH.
  - Error is set on that same edge iff Req_Last=0 and Count becomes DEPTH.
  - Req_Last=1 on the DEPTH-th word: Error=0.
- Done = (state==DONE) && !Imem_We. It rises the cycle after the final write strobe.
- In DONE: Req_Ready=0 and Req_Valid is ignored.
  - Start=1 -> Count=0, Error=0, state=LOAD. Imem_Addr and Imem_Wdata hold their values.
- Start in LOAD is ignored.
- Reset takes priority over Start and over an accept in the same cycle.

Decomposition:
- Shared package mips_isa_pkg. It holds:
  - 6-bit opcode constants (R 0, LW 35, SW 43, ADDI 8, ANDI 12, ORI 13, SLTI 10, XORI 14, BNE 5, J 2, JAL 3, LUI 15).
  - Funct constants (32, 34, 36, 37, 42).
  - 4-bit mnemonic codes: ADD 0, SUB 1, AND 2, OR 3, SLT 4, LW 5, SW 6, ADDI 7, ANDI 8, ORI 9, SLTI 10, XORI 11, BNE 12, J 13, JAL 14, LUI 15.
- The control decoder imports the same opcode constants.
- One sub-module: inst_encode. It is purely combinational (mnemonic + fields -> 32-bit word) and is reused by testbenches as a reference model.

Test Plan:
1. Drive reset=0 for one cycle -> Req_Ready=1, Imem_We=0, Count=0, Done=0, Error=0.
2. ADDI with rs=1, rt=2, imm=16'hFFFC, accepted at cycle N -> in cycle N+1: Imem_We=1, Imem_Addr=0, Imem_Wdata=32'h2022FFFC; Count=1.
3. Back-to-back requests, each accepted one cycle after the previous:
   - ADD rs=3, rt=4, rd=5 -> addr 0, 32'h00642820.
   - SW rs=29, rt=31, imm=4 -> addr 1, 32'hAFBF0004.
   - JAL target=26'h10 with Last=1 -> addr 2, 32'h0C000010.
   - Then Done=1 one cycle after the third strobe, Req_Ready=0, Error=0.
4. LUI with rs=7, rt=8, imm=16'h1234 -> Imem_Wdata=32'h3C081234 (rs zeroed).
5. DEPTH=4 with 4 accepts and Last=0 -> Req_Ready=0 after the 4th, Error=1, Done=1. Pulse Start -> Count=0, Error=0, Req_Ready=1, next accept writes addr 0.
6. Reset=0 in the cycle after an accept -> no Imem_We next cycle, Count=0, state LOAD.
